// File: rtl/gshare_btb_pred_pkg.sv
// bp_pkg: FSM state encoding, 2-bit counter encodings and saturating counter update shared by predictor files
package bp_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, UPDATE} state_t;
  localparam logic [1:0] SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3;
  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
    return up ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/gshare_btb_pred_if.sv
// gshare_btb_pred_if: predictor request/response bus; master drives start_pred/start_resolve/PC/actual_*/pr_hit, slave returns BR_PRED/TARGET/DONE
interface gshare_btb_pred_if #(parameter int W = 32);
  logic start_pred, start_resolve, actual_taken, pr_hit, BR_PRED, DONE;
  logic [W-1:0] PC, actual_target, TARGET;
  modport master(output start_pred, start_resolve, PC, actual_taken, actual_target, pr_hit, input BR_PRED, TARGET, DONE);
  modport slave(input start_pred, start_resolve, PC, actual_taken, actual_target, pr_hit, output BR_PRED, TARGET, DONE);
endinterface

// File: rtl/gshare_btb_pred_btb.sv
// bp_btb: set-assoc BTB; clk, rst (async active-low), i_pc[W-1:2] lookup/write address, i_we/i_target write, o_hit/o_target combinational lookup
module bp_btb #(
  parameter int W = 32,
  parameter int SETS = 16,
  parameter int WAYS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:2] i_pc,
  input  logic         i_we,
  input  logic [W-1:0] i_target,
  output logic         o_hit,
  output logic [W-1:0] o_target
);
  localparam int SB = $clog2(SETS);
  localparam int WB = WAYS > 1 ? $clog2(WAYS) : 1;
  logic [W-SB-3:0] r_tag [SETS][WAYS];
  logic [W-1:0] r_tgt [SETS][WAYS];
  logic r_val [SETS][WAYS];
  logic [WB-1:0] r_rr [SETS];
  logic [SB-1:0] w_set;
  logic [W-SB-3:0] w_tag;
  logic [WB-1:0] w_way, w_inv, w_wr;
  logic w_inv_ok;
  assign w_set = i_pc[SB+1:2];
  assign w_tag = i_pc[W-1:SB+2];
  always_comb begin
    o_hit = 1'b0;
    w_way = '0;
    w_inv = '0;
    w_inv_ok = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_val[w_set][i] && r_tag[w_set][i] == w_tag) begin
        o_hit = 1'b1;
        w_way = WB'(i);
      end
      if (!r_val[w_set][i]) begin
        w_inv_ok = 1'b1;
        w_inv = WB'(i);
      end
    end
    o_target = r_tgt[w_set][w_way];
  end
  assign w_wr = o_hit ? w_way : w_inv_ok ? w_inv : r_rr[w_set];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_val[s][w] <= 1'b0;
      end
    end else if (i_we) begin
      r_val[w_set][w_wr] <= 1'b1;
      if (!o_hit && !w_inv_ok) r_rr[w_set] <= WAYS > 1 ? r_rr[w_set] + 1'b1 : '0;
    end
  always_ff @(posedge clk)
    if (i_we) begin
      r_tag[w_set][w_wr] <= w_tag;
      r_tgt[w_set][w_wr] <= i_target;
    end
endmodule

// File: rtl/gshare_btb_pred.sv
// gshare_btb_pred: gshare direction predictor with BTB; clk, rst (async active-low), bus (slave: predict/resolve requests, BR_PRED/TARGET/DONE)
module gshare_btb_pred import bp_pkg::*; #(
  parameter int W = 32,
  parameter int GHR_BITS = 8,
  parameter int PHT_IDX_BITS = 10,
  parameter int BTB_SETS = 16,
  parameter int BTB_WAYS = 4
) (
  input logic clk,
  input logic rst,
  gshare_btb_pred_if.slave bus
);
  state_t r_state;
  logic r_pred_q, r_res_q, r_pend_pred, r_pend_res, r_taken, r_prh, r_br, r_done;
  logic [W-1:0] r_pc, r_act_tgt, r_tgt;
  logic [GHR_BITS-1:0] r_ghr, r_chk;
  logic [1:0] r_pht [2**PHT_IDX_BITS];
  logic w_pred_req, w_res_req, w_take_res, w_take_pred, w_hit, w_br;
  logic [W-1:0] w_btb_tgt, w_tgt;
  logic [PHT_IDX_BITS-1:0] w_pred_idx, w_res_idx;
  // rising edges are remembered until IDLE can take them; resolve wins a tie
  assign w_pred_req = (bus.start_pred & ~r_pred_q) | r_pend_pred;
  assign w_res_req = (bus.start_resolve & ~r_res_q) | r_pend_res;
  assign w_take_res = (r_state == IDLE) & w_res_req;
  assign w_take_pred = (r_state == IDLE) & ~w_res_req & w_pred_req;
  assign w_pred_idx = r_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(r_ghr);
  assign w_res_idx = r_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(r_chk);
  assign w_br = r_pht[w_pred_idx][1] & w_hit;
  assign w_tgt = w_br ? w_btb_tgt : r_pc + W'(4);
  assign bus.BR_PRED = r_br;
  assign bus.TARGET = r_tgt;
  assign bus.DONE = r_done;
  bp_btb #(.W(W), .SETS(BTB_SETS), .WAYS(BTB_WAYS)) u_btb (
    .clk(clk), .rst(rst), .i_pc(r_pc[W-1:2]), .i_we(r_state == UPDATE && r_taken),
    .i_target(r_act_tgt), .o_hit(w_hit), .o_target(w_btb_tgt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < 2**PHT_IDX_BITS; i++) r_pht[i] <= WNT;
    else if (r_state == UPDATE) r_pht[w_res_idx] <= sat_ctr(r_pht[w_res_idx], r_taken);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      {r_pred_q, r_res_q, r_pend_pred, r_pend_res, r_taken, r_prh, r_br, r_done} <= '0;
      r_pc <= '0;
      r_act_tgt <= '0;
      r_tgt <= '0;
      r_ghr <= '0;
      r_chk <= '0;
    end else begin
      r_done <= 1'b0;
      r_pred_q <= bus.start_pred;
      r_res_q <= bus.start_resolve;
      r_pend_pred <= w_pred_req & ~w_take_pred;
      r_pend_res <= w_res_req & ~w_take_res;
      case (r_state)
        IDLE:
          if (w_take_res) begin
            r_state <= UPDATE;
            r_done <= 1'b1;
            r_pc <= bus.PC;
            r_taken <= bus.actual_taken;
            r_act_tgt <= bus.actual_target;
            r_prh <= bus.pr_hit;
          end else if (w_take_pred) begin
            r_state <= LOOKUP;
            r_pc <= bus.PC;
          end
        LOOKUP: begin
          r_state <= RESP;
          r_done <= 1'b1;
          r_br <= w_br;
          r_tgt <= w_tgt;
          r_chk <= r_ghr;
          r_ghr <= {r_ghr[GHR_BITS-2:0], w_br};
        end
        RESP: r_state <= IDLE;
        UPDATE: begin
          r_state <= IDLE;
          if (!r_prh) r_ghr <= {r_chk[GHR_BITS-2:0], r_taken};
        end
      endcase
    end
endmodule
